// File: rtl/regbank_wb_arbiter.sv
// Write-back arbiter for the 32x32 register bank: round-robin ALU/load arbitration into one registered write port.
// Define REGBANK_FWD_EN to forward the staged write onto both read ports.
module regbank_wb_arbiter #(
    parameter int unsigned size      = 32,
    parameter int unsigned mem_depth = 32
) (
    input  logic                         CLK,
    input  logic                         aRSTn,
    input  logic                         ALU_VALID,
    input  logic [$clog2(mem_depth)-1:0] ALU_RD,
    input  logic [size-1:0]              ALU_DATA,
    output logic                         ALU_READY,
    input  logic                         MEM_VALID,
    input  logic [$clog2(mem_depth)-1:0] MEM_RD,
    input  logic [size-1:0]              MEM_DATA,
    output logic                         MEM_READY,
    output logic                         ENA_WRITE,
    output logic [$clog2(mem_depth)-1:0] WRITE_REG,
    output logic [size-1:0]              WRITE_DATA,
    input  logic [$clog2(mem_depth)-1:0] READREG_1,
    input  logic [$clog2(mem_depth)-1:0] READREG_2,
    input  logic [size-1:0]              bank_data1,
    input  logic [size-1:0]              bank_data2,
    output logic [size-1:0]              read_data1,
    output logic [size-1:0]              read_data2
);

    localparam int unsigned AW = $clog2(mem_depth);
    localparam logic        GRANT_ALU = 1'b0;
    localparam logic        GRANT_MEM = 1'b1;

    logic            ena_write_q, ena_write_d;
    logic [AW-1:0]   write_reg_q, write_reg_d;
    logic [size-1:0] write_data_q, write_data_d;
    logic            last_grant_q, last_grant_d;
    logic            alu_grant_c, mem_grant_c;

    // Round-robin grant; the requester not granted last wins a tie.
    always_comb begin
        alu_grant_c = 1'b0;
        mem_grant_c = 1'b0;
        if (aRSTn) begin
            if (ALU_VALID && MEM_VALID) begin
                alu_grant_c = (last_grant_q == GRANT_MEM);
                mem_grant_c = (last_grant_q == GRANT_ALU);
            end else begin
                alu_grant_c = ALU_VALID;
                mem_grant_c = MEM_VALID;
            end
        end
    end

    assign ALU_READY = alu_grant_c;
    assign MEM_READY = mem_grant_c;

    // Output stage next state; register 0 writes are accepted but never enabled.
    always_comb begin
        ena_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        last_grant_d = last_grant_q;
        if (alu_grant_c) begin
            ena_write_d  = (ALU_RD != AW'(0));
            write_reg_d  = ALU_RD;
            write_data_d = ALU_DATA;
            last_grant_d = GRANT_ALU;
        end else if (mem_grant_c) begin
            ena_write_d  = (MEM_RD != AW'(0));
            write_reg_d  = MEM_RD;
            write_data_d = MEM_DATA;
            last_grant_d = GRANT_MEM;
        end
    end

    always_ff @(posedge CLK or negedge aRSTn) begin
        if (!aRSTn) begin
            ena_write_q  <= 1'b0;
            write_reg_q  <= AW'(0);
            write_data_q <= size'(0);
            last_grant_q <= GRANT_MEM;
        end else begin
            ena_write_q  <= ena_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign ENA_WRITE  = ena_write_q;
    assign WRITE_REG  = write_reg_q;
    assign WRITE_DATA = write_data_q;

    // Read ports: register 0 is hard zero, otherwise bank (or staged write when forwarding).
    always_comb begin
        read_data1 = bank_data1;
        read_data2 = bank_data2;
`ifdef REGBANK_FWD_EN
        if (ena_write_q && (READREG_1 == write_reg_q)) begin
            read_data1 = write_data_q;
        end
        if (ena_write_q && (READREG_2 == write_reg_q)) begin
            read_data2 = write_data_q;
        end
`endif
        if (READREG_1 == AW'(0)) begin
            read_data1 = size'(0);
        end
        if (READREG_2 == AW'(0)) begin
            read_data2 = size'(0);
        end
    end

endmodule
